axil_accel_regfile: RTL and testbench
=====================================

Name: axil_accel_regfile

Overview:
AXI4-Lite slave (responder) register file that terminates the S00_AXI control port driven by the PS / master VIP. It exposes four 32-bit registers: a control register, a status register and two argument registers. It converts AXI4-Lite register writes into a start pulse and argument values for the accelerator datapath, and reports busy/done status back to software.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported, and elaboration fails otherwise.
C_S_AXI_ADDR_WIDTH, 4, byte address width; the block decodes bits [3:2] and ignores bits [1:0].

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  4/3/1/1  write address channel; AWPROT is ignored
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  4/3/1/1  read address channel
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel
start_o  out  1  one-cycle start pulse to the accelerator
arg0_o, arg1_o  out  32 each  argument register contents
busy_i  in  1  accelerator busy level
done_i  in  1  accelerator done pulse

Behaviour:
- Reset: asynchronous on S_AXI_ARESETN low.
  - All registers, AWREADY, WREADY, BVALID, ARREADY, RVALID and start_o reset to 0.
  - BRESP, RRESP and RDATA reset to 0.
  - Outstanding transactions are dropped.
- Register map:
  - 0x0 CTRL (RW). bit0 GO; bits[31:1] are scratch.
  - 0x4 STATUS. bit0 BUSY is read-only and mirrors busy_i. bit1 DONE is sticky, set by done_i and cleared by writing 1 (W1C). Other bits read 0.
  - 0x8 ARG0 (RW).
  - 0xC ARG1 (RW).
- Write handshake:
  - AWREADY and WREADY are asserted together for exactly one cycle, in the cycle after AWVALID and WVALID are both seen high, and only while AWREADY=0 and BVALID=0.
  - AWVALID without WVALID, or the reverse, stalls with no acceptance.
  - On the handshake edge the addressed register is updated per byte under WSTRB.
  - BVALID rises on the following cycle with BRESP=OKAY and holds until BREADY is high.
  - Only one write is outstanding at a time.
- GO semantics:
  - A write with WSTRB[0]=1 and WDATA[0]=1 to CTRL asserts start_o for exactly one cycle, the cycle after the handshake.
  - The GO bit reads back 1 until done_i arrives, then hardware clears it.
  - Writing GO=1 while busy_i=1 is ignored: no pulse is generated and the bit is unchanged.
- Read handshake:
  - ARREADY is asserted for one cycle, in the cycle after ARVALID is seen with ARREADY=0 and RVALID=0.
  - RDATA is latched at the handshake edge; RVALID rises the next cycle with RRESP=OKAY and holds until RREADY is high.
  - RDATA stays stable while RVALID=1.
- Concurrency:
  - Read and write channels operate independently and may complete in the same cycle.
  - A read in the same cycle as a write to the same register returns the pre-write value.
- Simultaneous events on STATUS.DONE: done_i set and a W1C clear in the same cycle leaves DONE=1, because set wins.
- Latency from VALID first asserted (responder ready immediately):
  - Write: BVALID after 2 cycles.
  - Read: RVALID after 2 cycles.

Decomposition:
- Package axil_accel_pkg holds:
  - register offset localparams (ADDR_CTRL=2'd0, ADDR_STATUS=2'd1, ADDR_ARG0=2'd2, ADDR_ARG1=2'd3);
  - RESP_OKAY=2'b00;
  - CTRL/STATUS bit-index constants.
- No sub-module; a single flat module is natural.

Test Plan:
- Reset for 200 ns, then write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC and read back -> CTRL=0x1 (GO set, start_o pulsed once), STATUS=0x0, ARG0=0x3, ARG1=0x4, all responses OKAY.
- Write 0xAABBCCDD to 0x8 with WSTRB=0b0101 over an initial 0x0 -> ARG0 reads 0x00BB00DD and arg0_o matches.
- Write GO with busy_i=0, then pulse done_i -> start_o high exactly 1 cycle; STATUS reads 0x2; CTRL bit0 reads 0. Write 0x2 to 0x4 -> STATUS reads 0x0.
- Hold BREADY/RREADY low for 10 cycles -> BVALID/RVALID and RDATA stay stable and no new handshake occurs. Present AWVALID 3 cycles before WVALID -> acceptance only after both are high.
- Issue W1C of DONE in the same cycle as a done_i pulse -> DONE reads 1. Write GO while busy_i=1 -> no start_o pulse.
- Deassert S_AXI_ARESETN while BVALID=1 -> BVALID, start_o and all registers go to 0 immediately (asynchronous); after release, a read of 0x8 returns 0x0.

Source files
------------

// File: rtl/axil_accel_pkg.sv
// axil_accel_pkg: register map, response codes and helpers shared by the accelerator register file
package axil_accel_pkg;
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_ARG0   = 2'd2;
  localparam logic [1:0] ADDR_ARG1   = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int CTRL_GO   = 0;
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/axil_accel_regfile.sv
// axil_accel_regfile: AXI4-Lite register file driving accelerator start/args and reporting busy/done
module axil_accel_regfile
  import axil_accel_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            start_o,
  output logic [31:0]                     arg0_o,
  output logic [31:0]                     arg1_o,
  input  logic                            busy_i,
  input  logic                            done_i
);
  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_width
    $error("axil_accel_regfile supports only a 32-bit data bus");
  end

  logic [31:0] ctrl, ctrl_next, ctrl_merged, rd_mux, status;
  logic        done_q, done_next, go_next, wr_en, wr_ctrl, wr_go_field, go_req, w1c_done;
  logic [1:0]  wsel, rsel;
  logic        unused_ok;

  assign unused_ok   = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;

  // Decode the accepted write, the GO/W1C side effects and the read-data source
  always_comb begin
    wr_en       = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
    wsel        = S_AXI_AWADDR[3:2];
    rsel        = S_AXI_ARADDR[3:2];
    wr_ctrl     = wr_en && wsel == ADDR_CTRL;
    wr_go_field = wr_ctrl && S_AXI_WSTRB[0] && !busy_i;
    go_req      = wr_go_field && S_AXI_WDATA[CTRL_GO];
    ctrl_merged = apply_strb(ctrl, S_AXI_WDATA, S_AXI_WSTRB);
    go_next     = wr_go_field ? S_AXI_WDATA[CTRL_GO] : ctrl[CTRL_GO] & ~done_i;
    ctrl_next   = wr_ctrl ? {ctrl_merged[31:1], go_next} : {ctrl[31:1], go_next};
    w1c_done    = wr_en && wsel == ADDR_STATUS && S_AXI_WSTRB[0] && S_AXI_WDATA[STAT_DONE];
    done_next   = done_i | (done_q & ~w1c_done);
    status      = (32'(done_q) << STAT_DONE) | (32'(busy_i) << STAT_BUSY);
    rd_mux      = rsel == ADDR_CTRL   ? ctrl :
                  rsel == ADDR_STATUS ? status :
                  rsel == ADDR_ARG0   ? arg0_o : arg1_o;
  end

  // Write channel: one-cycle AW/W acceptance once both are valid, then hold B until taken
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
    end else begin
      S_AXI_AWREADY <= !S_AXI_AWREADY && !S_AXI_BVALID && S_AXI_AWVALID && S_AXI_WVALID;
      S_AXI_WREADY  <= !S_AXI_AWREADY && !S_AXI_BVALID && S_AXI_AWVALID && S_AXI_WVALID;
      S_AXI_BVALID  <= wr_en ? 1'b1 : S_AXI_BVALID && !S_AXI_BREADY;
    end
  end

  // Register file and start pulse; GO self-clears on done, DONE is sticky with set winning over W1C
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl    <= '0;
      done_q  <= 1'b0;
      arg0_o  <= '0;
      arg1_o  <= '0;
      start_o <= 1'b0;
    end else begin
      ctrl    <= ctrl_next;
      done_q  <= done_next;
      arg0_o  <= wr_en && wsel == ADDR_ARG0 ? apply_strb(arg0_o, S_AXI_WDATA, S_AXI_WSTRB) : arg0_o;
      arg1_o  <= wr_en && wsel == ADDR_ARG1 ? apply_strb(arg1_o, S_AXI_WDATA, S_AXI_WSTRB) : arg1_o;
      start_o <= go_req;
    end
  end

  // Read channel: one-cycle AR acceptance, data captured at the handshake and held while RVALID
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      S_AXI_ARREADY <= !S_AXI_ARREADY && !S_AXI_RVALID && S_AXI_ARVALID;
      S_AXI_RVALID  <= S_AXI_ARREADY && S_AXI_ARVALID ? 1'b1 : S_AXI_RVALID && !S_AXI_RREADY;
      S_AXI_RDATA   <= S_AXI_ARREADY && S_AXI_ARVALID ? rd_mux : S_AXI_RDATA;
    end
  end
endmodule

// File: tb/tb_axil_accel_regfile.sv
// tb_axil_accel_regfile: directed AXI4-Lite traffic with queued expected responses and a response monitor
module tb_axil_accel_regfile;
  logic        clk = 0, rst_n = 0;
  logic [3:0]  awaddr = 0, araddr = 0, wstrb = 0;
  logic [2:0]  awprot = 0, arprot = 0;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 1;
  logic        arvalid = 0, arready, rvalid, rready = 1;
  logic [31:0] wdata = 0, rdata, arg0, arg1;
  logic [1:0]  bresp, rresp;
  logic        start, busy = 0, done = 0;
  int          total = 0, bad = 0, starts = 0, errs;
  logic [1:0]  bq[$];
  logic [31:0] rq[$];

  axil_accel_regfile dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .start_o(start), .arg0_o(arg0), .arg1_o(arg1), .busy_i(busy), .done_i(done)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Response monitor: every B/R handshake is matched against the oldest queued expectation
  always @(negedge clk) if (rst_n) begin
    if (start) starts++;
    if (bvalid && bready) begin
      if (bq.size() == 0) chk("unexpected_b", 1, 0);
      else chk("bresp", 32'(bresp), 32'(bq.pop_front()));
    end
    if (rvalid && rready) begin
      if (rq.size() == 0) chk("unexpected_r", 1, 0);
      else begin
        chk("rdata", rdata, rq.pop_front());
        chk("rresp", 32'(rresp), 0);
      end
    end
  end

  task automatic wait_aw(bit pd);
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (awready) break;
    end
    if (n == 50) chk("aw_timeout", 0, 1);
    chk("wready_with_awready", 32'(wready), 32'(awready));
    if (pd) done = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; done = 0;
  endtask

  task automatic wait_b();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bvalid && bready) break;
    end
    if (n == 50) chk("b_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_ar();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (arready) break;
    end
    if (n == 50) chk("ar_timeout", 0, 1);
    @(posedge clk); #1;
    arvalid = 0;
  endtask

  task automatic wait_r();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rvalid && rready) break;
    end
    if (n == 50) chk("r_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic aw_issue(logic [3:0] a, logic [31:0] d, logic [3:0] s, bit pd = 0);
    bq.push_back(2'b00);
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    wait_aw(pd);
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] d, logic [3:0] s = 4'hF, bit pd = 0);
    aw_issue(a, d, s, pd);
    wait_b();
  endtask

  task automatic rd_issue(logic [3:0] a, logic [31:0] e);
    rq.push_back(e);
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    wait_ar();
  endtask

  task automatic rd(logic [3:0] a, logic [31:0] e);
    rd_issue(a, e);
    wait_r();
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 done = 1;
    @(posedge clk); #1 done = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #100;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_arg0", arg0, 0);
    chk("rst_rdata", rdata, 0);
    #100;
    @(negedge clk) rst_n = 1;
    // basic write/readback
    wr(4'h0, 32'h1); wr(4'h4, 32'h2); wr(4'h8, 32'h3); wr(4'hC, 32'h4);
    repeat (2) @(negedge clk);
    chk("start_count_t1", starts, 1);
    rd(4'h0, 32'h1); rd(4'h4, 32'h0); rd(4'h8, 32'h3); rd(4'hC, 32'h4);
    chk("arg1_port", arg1, 32'h4);
    // byte strobes
    wr(4'h8, 32'h0);
    wr(4'h8, 32'hAABBCCDD, 4'b0101);
    rd(4'h8, 32'h00BB00DD);
    chk("arg0_port", arg0, 32'h00BB00DD);
    // GO pulse, done sets DONE and clears GO, W1C clears DONE
    starts = 0;
    wr(4'h0, 32'h1);
    repeat (3) @(negedge clk);
    chk("start_one_cycle", starts, 1);
    pulse_done();
    rd(4'h4, 32'h2); rd(4'h0, 32'h0);
    wr(4'h4, 32'h2);
    rd(4'h4, 32'h0);
    // backpressure on B with a second write waiting
    bready = 0;
    aw_issue(4'h8, 32'h55, 4'hF);
    bq.push_back(2'b00);
    awaddr = 4'hC; wdata = 32'h66; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bvalid || bresp != 2'b00 || awready || wready) errs++;
    end
    chk("b_hold", errs, 0);
    @(posedge clk); #1 bready = 1;
    wait_b();
    wait_aw(0);
    wait_b();
    // backpressure on R with a second read waiting
    rready = 0;
    rd_issue(4'h8, 32'h55);
    rq.push_back(32'h66);
    araddr = 4'hC; arvalid = 1;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rvalid || rdata != 32'h55 || arready) errs++;
    end
    chk("r_hold", errs, 0);
    @(posedge clk); #1 rready = 1;
    wait_r();
    wait_ar();
    wait_r();
    // AW leads W by three cycles
    bq.push_back(2'b00);
    @(posedge clk); #1;
    awaddr = 4'hC; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 0;
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (awready || wready) errs++;
    end
    chk("aw_without_w", errs, 0);
    @(posedge clk); #1 wvalid = 1;
    wait_aw(0);
    wait_b();
    rd(4'hC, 32'h77);
    // DONE set beats W1C in the same cycle
    pulse_done();
    rd(4'h4, 32'h2);
    wr(4'h4, 32'h2, 4'hF, 1);
    rd(4'h4, 32'h2);
    wr(4'h4, 32'h2);
    rd(4'h4, 32'h0);
    // GO ignored while busy
    busy = 1;
    starts = 0;
    wr(4'h0, 32'h1);
    repeat (3) @(negedge clk);
    chk("no_start_busy", starts, 0);
    rd(4'h0, 32'h0);
    rd(4'h4, 32'h1);
    busy = 0;
    // asynchronous reset with a pending B
    bready = 0;
    aw_issue(4'h8, 32'h99, 4'hF);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bvalid) break;
    end
    chk("bvalid_pre_rst", 32'(bvalid), 1);
    chk("arg0_pre_rst", arg0, 32'h99);
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("async_bvalid", 32'(bvalid), 0);
    chk("async_arg0", arg0, 0);
    chk("async_start", 32'(start), 0);
    bq.delete(); rq.delete();
    #20;
    @(negedge clk) rst_n = 1;
    bready = 1;
    rd(4'h8, 32'h0);
    rd(4'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("bq_empty", bq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
